// File: rtl/q_6_25_ring_sched.sv
// Round-robin scheduler granting one of two clients the six-phase T0..T5 ring for N passes.
// Latency: grant and T0 appear one edge after req in IDLE; done pulses the cycle after the last T5.
// Backpressure: hold freezes ring and pass counter in RUN; req is ignored while a sequence runs.
module q_6_25_ring_sched #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [PW-1:0] npass0,
    input  logic [PW-1:0] npass1,
    input  logic          hold,
    output logic [5:0]    t,
    output logic [1:0]    gnt,
    output logic          busy,
    output logic          done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic          last;
    logic          win;
    logic [PW-1:0] sel_np;
    // Holds remaining passes minus one, so npass=0 naturally wraps to 2^PW passes.
    logic [PW-1:0] cnt;

    always_comb begin
        win = 1'b0;
        case (req)
            2'b10:   win = 1'b1;
            2'b11:   win = ~last;
            default: win = 1'b0;
        endcase
        sel_np = win ? npass1 : npass0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            t     <= 6'b000000;
            gnt   <= 2'b00;
            busy  <= 1'b0;
            done  <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        state <= RUN;
                        t     <= 6'b000001;
                        gnt   <= win ? 2'b10 : 2'b01;
                        busy  <= 1'b1;
                        cnt   <= sel_np - {{(PW-1){1'b0}}, 1'b1};
                        last  <= win;
                    end
                end
                RUN: begin
                    if (!hold) begin
                        if (t[5]) begin
                            if (cnt == '0) begin
                                state <= IDLE;
                                t     <= 6'b000000;
                                gnt   <= 2'b00;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                cnt <= cnt - {{(PW-1){1'b0}}, 1'b1};
                                t   <= 6'b000001;
                            end
                        end else begin
                            t <= {t[4:0], t[5]};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_q_6_25_ring_sched.sv
// Bench for q_6_25_ring_sched: per-cycle comparison against a pass/phase model plus directed literal checks.
module tb_q_6_25_ring_sched;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [3:0] npass0;
    logic [3:0] npass1;
    logic       hold;
    logic [5:0] t;
    logic [1:0] gnt;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_fail = 0;

    q_6_25_ring_sched #(.PW(4)) dut (
        .clk(clk), .rst(rst), .req(req), .npass0(npass0), .npass1(npass1),
        .hold(hold), .t(t), .gnt(gnt), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a sequence is a client, a number of passes left and a phase 0..5.
    bit m_busy   = 0;
    bit m_done   = 0;
    int m_client = 0;
    int m_phase  = 0;
    int m_left   = 0;
    int m_last   = 1;

    always @(posedge clk) begin
        int w;
        int np;
        if (rst) begin
            m_busy = 0; m_done = 0; m_last = 1; m_phase = 0; m_left = 0;
        end else if (m_busy) begin
            m_done = 0;
            if (!hold) begin
                if (m_phase == 5) begin
                    if (m_left == 1) begin
                        m_busy = 0;
                        m_done = 1;
                    end else begin
                        m_left  = m_left - 1;
                        m_phase = 0;
                    end
                end else begin
                    m_phase = m_phase + 1;
                end
            end
        end else begin
            m_done = 0;
            if (req != 2'b00) begin
                if (req == 2'b11) w = (m_last == 0) ? 1 : 0;
                else              w = req[1] ? 1 : 0;
                np       = (w == 1) ? int'(npass1) : int'(npass0);
                m_left   = (np == 0) ? 16 : np;
                m_client = w;
                m_phase  = 0;
                m_busy   = 1;
                m_last   = w;
            end
        end
        #1;
        chk("model_t",    int'(t),    m_busy ? (1 << m_phase) : 0);
        chk("model_gnt",  int'(gnt),  m_busy ? (1 << m_client) : 0);
        chk("model_busy", int'(busy), int'(m_busy));
        chk("model_done", int'(done), int'(m_done));
        if (busy) chk("t_onehot", int'($countones(t)), 1);
        chk("gnt_atmost1", int'($countones(gnt) <= 1), 1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = 2'b00; hold = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for busy, counts busy cycles, then checks the done cycle that follows.
    task automatic measure(input string name, input bit drop_req, input int exp_cyc,
                           output int gnt_seen, output int idle_wait);
        int cyc;
        idle_wait = 0;
        while (!busy && idle_wait < 40) begin
            @(negedge clk);
            idle_wait++;
        end
        gnt_seen = int'(gnt);
        if (drop_req) req = 2'b00;
        cyc = 0;
        while (busy && cyc < 400) begin
            cyc++;
            @(negedge clk);
        end
        chk({name, "_busy_cycles"}, cyc, exp_cyc);
        chk({name, "_done"}, int'(done), 1);
    endtask

    initial begin
        int g;
        int iw;
        int cyc;
        bit held;
        rst = 1'b1; req = 2'b00; hold = 1'b0; npass0 = 4'd1; npass1 = 4'd1;
        repeat (2) @(negedge clk);
        chk("reset_t", int'(t), 0);
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_busy_done", int'({busy, done}), 0);
        rst = 1'b0;

        // Basic single pass with literal walk of T0..T5.
        req = 2'b01; npass0 = 4'd1;
        @(negedge clk);
        chk("basic_gnt", int'(gnt), 1);
        req = 2'b00;
        for (int i = 0; i < 6; i++) begin
            chk("basic_walk", int'(t), 1 << i);
            @(negedge clk);
        end
        chk("basic_end_t", int'(t), 0);
        chk("basic_end_done", int'(done), 1);
        @(negedge clk);
        chk("basic_done_once", int'(done), 0);

        // Contention: grants alternate starting with client 0.
        do_reset();
        npass0 = 4'd2; npass1 = 4'd2; req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            measure("rr", 1'b0, 12, g, iw);
            chk("rr_gnt", g, (k % 2 == 0) ? 1 : 2);
            if (k > 0) chk("rr_gap", iw, 1);
        end
        req = 2'b00;
        repeat (2) @(negedge clk);

        // Hold for three cycles at T2.
        npass1 = 4'd1; req = 2'b10;
        iw = 0;
        while (!busy && iw < 20) begin @(negedge clk); iw++; end
        req = 2'b00;
        cyc = 0; held = 0;
        while (busy && cyc < 100) begin
            if (t == 6'b000100 && !held) begin
                held = 1; hold = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    cyc++;
                    @(negedge clk);
                    chk("hold_t", int'(t), 4);
                end
                hold = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        chk("hold_busy_cycles", cyc, 9);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_idle", int'({t, gnt, busy, done}), 0);
        end
        hold = 1'b0;

        // Pass count wrap and maximum non-zero count.
        npass0 = 4'd0; req = 2'b01;
        measure("wrap0", 1'b1, 96, g, iw);
        @(negedge clk);
        npass0 = 4'd15; req = 2'b01;
        measure("wrap15", 1'b1, 90, g, iw);

        // Asynchronous reset mid-sequence at T3.
        @(negedge clk);
        npass0 = 4'd3; req = 2'b01;
        iw = 0;
        while (t != 6'b001000 && iw < 40) begin @(negedge clk); iw++; end
        chk("rst_reach_t3", int'(t), 8);
        req = 2'b00;
        #2 rst = 1'b1;
        #1;
        chk("rst_async_t", int'(t), 0);
        chk("rst_async_rest", int'({gnt, busy, done}), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_no_done", int'(done), 0);
        end
        req = 2'b11; npass0 = 4'd1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_gnt", int'(gnt), 1);
        req = 2'b00;
        iw = 0;
        while (busy && iw < 20) begin @(negedge clk); iw++; end

        // Request withdrawn one cycle after grant.
        @(negedge clk);
        npass0 = 4'd2; req = 2'b01;
        measure("withdraw", 1'b1, 12, g, iw);
        chk("withdraw_gnt", g, 1);

        // Random traffic checked by the model each cycle.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            req    = 2'($urandom_range(0, 3));
            npass0 = 4'($urandom_range(0, 3));
            npass1 = 4'($urandom_range(0, 3));
            hold   = ($urandom_range(0, 7) == 0);
        end
        req = 2'b00; hold = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
